// File: rtl/vm2002_common_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vm2002_common_pkg
// Purpose  : Shared coin encodings, change-dispenser state type and coin
//            values for the vm2002 vending controller.
// Revision : 1.0  initial release
// ============================================================================
package vm2002_common_pkg;

  // Coin encoding shared by the acceptor, refill path and return mechanism
  typedef enum logic [1:0] {
    COIN_NONE    = 2'b00,
    COIN_NICKEL  = 2'b01,
    COIN_DIME    = 2'b10,
    COIN_QUARTER = 2'b11
  } coins_t;

  // Change dispenser states, prefixed to keep clear of the main FSM's names
  typedef enum logic [1:0] {
    CHG_IDLE    = 2'd0,
    CHG_SELECT  = 2'd1,
    CHG_PRESENT = 2'd2,
    CHG_DONE    = 2'd3
  } chg_state_t;

  localparam logic [7:0] NICKEL_VALUE  = 8'd5;
  localparam logic [7:0] DIME_VALUE    = 8'd10;
  localparam logic [7:0] QUARTER_VALUE = 8'd25;

  // Cent value of a coin; COIN_NONE is worth nothing
  function automatic logic [7:0] coin_value(input coins_t coin);
    logic [7:0] value;
    case (coin)
      COIN_NICKEL:  value = NICKEL_VALUE;
      COIN_DIME:    value = DIME_VALUE;
      COIN_QUARTER: value = QUARTER_VALUE;
      default:      value = 8'd0;
    endcase
    return value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vm2002_coin_inventory.sv
`default_nettype none
// ============================================================================
// Module   : vm2002_coin_inventory
// Purpose  : Per-denomination coin stock. Three saturating 4-bit counters;
//            a refill and a payout decrement of the same coin cancel out.
// Revision : 1.0  initial release
// ============================================================================
module vm2002_coin_inventory
  import vm2002_common_pkg::*;
#(
  parameter int unsigned INIT_COUNT = 8,
  parameter int unsigned MAX_COUNT  = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       refill_valid_i,
  input  logic [1:0] refill_coin_i,
  input  logic       dec_valid_i,
  input  logic [1:0] dec_coin_i,
  output logic [3:0] quarter_count_o,
  output logic [3:0] dime_count_o,
  output logic [3:0] nickel_count_o
);

  // Slot gi holds the coin whose code is gi+1 (nickel, dime, quarter)
  logic [11:0] counts;

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    logic [3:0] count_q;
    logic [3:0] count_d;
    logic       inc;
    logic       dec;

    assign inc = refill_valid_i && (refill_coin_i == 2'(gi + 1));
    assign dec = dec_valid_i    && (dec_coin_i    == 2'(gi + 1));

    // Next count: simultaneous refill and payout of this coin leave it as is
    always_comb begin
      count_d = count_q;
      if (inc && !dec) begin
        if (count_q < 4'(MAX_COUNT)) count_d = count_q + 4'd1;
      end else if (dec && !inc) begin
        if (count_q != 4'd0) count_d = count_q - 4'd1;
      end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count_q <= 4'(INIT_COUNT);
      else        count_q <= count_d;
    end

    assign counts[4*gi +: 4] = count_q;
  end

  assign nickel_count_o  = counts[3:0];
  assign dime_count_o    = counts[7:4];
  assign quarter_count_o = counts[11:8];

endmodule
`default_nettype wire

// File: rtl/vm2002_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : vm2002_change_dispenser
// Purpose  : Greedy change payout (quarter, dime, nickel), one coin per
//            handshake with the return mechanism, with shortfall reporting.
// Revision : 1.0  initial release
// ============================================================================
module vm2002_change_dispenser
  import vm2002_common_pkg::*;
#(
  parameter int unsigned INIT_COUNT = 8,
  parameter int unsigned MAX_COUNT  = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       change_req_i,
  input  logic [7:0] change_amount_i,
  output logic       change_busy_o,
  output logic       change_done_o,
  output logic       change_short_o,
  output logic [7:0] change_remaining_o,
  output logic       coin_valid_o,
  output logic [1:0] coin_type_o,
  input  logic       coin_ack_i,
  input  logic       refill_valid_i,
  input  logic [1:0] refill_coin_i,
  output logic [3:0] quarter_count_o,
  output logic [3:0] dime_count_o,
  output logic [3:0] nickel_count_o
);

  chg_state_t state_q, state_d;
  logic [7:0] remaining_q, remaining_d;
  coins_t     coin_type_q, coin_type_d;
  logic       short_q, short_d;
  coins_t     pick;
  logic       dec_valid;
  logic [3:0] q_cnt, d_cnt, n_cnt;

  vm2002_coin_inventory #(
    .INIT_COUNT (INIT_COUNT),
    .MAX_COUNT  (MAX_COUNT)
  ) u_inventory (
    .clk             (clk),
    .rst_n           (rst_n),
    .refill_valid_i  (refill_valid_i),
    .refill_coin_i   (refill_coin_i),
    .dec_valid_i     (dec_valid),
    .dec_coin_i      (coin_type_q),
    .quarter_count_o (q_cnt),
    .dime_count_o    (d_cnt),
    .nickel_count_o  (n_cnt)
  );

  // Largest coin that fits the remaining amount and is in stock
  always_comb begin
    pick = COIN_NONE;
    if (remaining_q >= QUARTER_VALUE && q_cnt != 4'd0)     pick = COIN_QUARTER;
    else if (remaining_q >= DIME_VALUE && d_cnt != 4'd0)   pick = COIN_DIME;
    else if (remaining_q >= NICKEL_VALUE && n_cnt != 4'd0) pick = COIN_NICKEL;
  end

  // The accepted coin leaves inventory on the ack cycle
  assign dec_valid = (state_q == CHG_PRESENT) && coin_ack_i;

  // Next-state logic for the payout sequence
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    coin_type_d = coin_type_q;
    short_d     = short_q;
    case (state_q)
      CHG_IDLE: begin
        if (change_req_i) begin
          remaining_d = change_amount_i;
          short_d     = 1'b0;
          state_d     = CHG_SELECT;
        end
      end
      CHG_SELECT: begin
        if (pick != COIN_NONE) begin
          coin_type_d = pick;
          state_d     = CHG_PRESENT;
        end else begin
          short_d = (remaining_q != 8'd0);
          state_d = CHG_DONE;
        end
      end
      CHG_PRESENT: begin
        if (coin_ack_i) begin
          // SELECT already guaranteed remaining covers this coin
          remaining_d = remaining_q - coin_value(coin_type_q);
          state_d     = CHG_SELECT;
        end
      end
      CHG_DONE: state_d = CHG_IDLE;
      default:  state_d = CHG_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CHG_IDLE;
      remaining_q <= 8'd0;
      coin_type_q <= COIN_NONE;
      short_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      coin_type_q <= coin_type_d;
      short_q     <= short_d;
    end
  end

  // Outputs decoded from state so reset removes coin_valid at once
  assign change_busy_o      = (state_q != CHG_IDLE);
  assign change_done_o      = (state_q == CHG_DONE);
  assign change_short_o     = short_q;
  assign change_remaining_o = remaining_q;
  assign coin_valid_o       = (state_q == CHG_PRESENT);
  assign coin_type_o        = coin_type_q;
  assign quarter_count_o    = q_cnt;
  assign dime_count_o       = d_cnt;
  assign nickel_count_o     = n_cnt;

endmodule
`default_nettype wire
